// File: rtl/video_pkg.sv
// Shared video definitions for the scandoubler path: default widths,
// the packed pixel layout and the sync polarity used by the PET core.
package video_pkg;

  localparam int HCNT_W_DEF  = 10;
  localparam int COLOR_W_DEF = 8;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sd_line_ram.sv
// Ping-pong line buffer storage: one write port, one registered read port,
// both on clk_sys. The address MSB selects the bank.
module sd_line_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24
) (
  input  logic              clk_sys,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_sys) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/scandoubler.sv
// Line doubler: captures each 15 kHz core line and replays the previous one
// twice at ce_pix_x2 with regenerated syncs, or passes video through registered.
module scandoubler
  import video_pkg::*;
#(
  parameter int HCNT_W  = HCNT_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic               ce_pix_x2,
  input  logic               enable,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  input  logic               HSync_in,
  input  logic               VSync_in,
  output logic [COLOR_W-1:0] R_out,
  output logic [COLOR_W-1:0] G_out,
  output logic [COLOR_W-1:0] B_out,
  output logic               HSync_out,
  output logic               VSync_out
);

  localparam int              PIX_W     = 3 * COLOR_W;
  localparam logic [HCNT_W-1:0] CNT_MAX = '1;
  localparam logic [HCNT_W-1:0] CNT_ONE = HCNT_W'(1);
  localparam logic            SYNC_IDLE = ~SYNC_ACTIVE;

  logic              r_hs_in;
  logic              r_vs_in;
  logic [HCNT_W-1:0] r_in_hcnt;
  logic [HCNT_W-1:0] r_hs_cnt;
  logic [HCNT_W-1:0] r_hs_len;
  logic [HCNT_W-1:0] r_line_len;
  logic              r_seen;
  logic              r_wsel;
  logic [HCNT_W-1:0] r_sd_hcnt;
  logic              r_s1_hs_low;
  logic              r_s1_blank;
  logic              r_s1_len_zero;
  logic              r_s1_vs;

  logic              w_line_start;
  logic              w_hs_rise;
  logic              w_wr_bank;
  logic [HCNT_W-1:0] w_wr_col;
  logic              w_we;
  logic [HCNT_W:0]   w_waddr;
  logic [HCNT_W:0]   w_raddr;
  logic [PIX_W-1:0]  w_wdata;
  logic [PIX_W-1:0]  w_rdata;
  logic              w_hs_active;

  assign w_line_start = ce_pix && (r_hs_in != SYNC_ACTIVE) && (HSync_in == SYNC_ACTIVE);
  assign w_hs_rise    = ce_pix && (r_hs_in == SYNC_ACTIVE) && (HSync_in != SYNC_ACTIVE);

  // The line-start pixel is column 0 of the freshly selected bank.
  assign w_wr_bank = w_line_start ? ~r_wsel : r_wsel;
  assign w_wr_col  = w_line_start ? '0 : r_in_hcnt;
  assign w_we      = ce_pix && (w_line_start || (r_in_hcnt != CNT_MAX));
  assign w_waddr   = {w_wr_bank, w_wr_col};
  assign w_wdata   = {R_in, G_in, B_in};
  assign w_raddr   = {~r_wsel, r_sd_hcnt};

  sd_line_ram #(
    .ADDR_W(HCNT_W + 1),
    .DATA_W(PIX_W)
  ) u_line_ram (
    .clk_sys (clk_sys),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // A line length is only trusted once a full line has been seen since reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_in    <= SYNC_IDLE;
      r_vs_in    <= SYNC_IDLE;
      r_in_hcnt  <= '0;
      r_hs_cnt   <= '0;
      r_hs_len   <= '0;
      r_line_len <= '0;
      r_seen     <= 1'b0;
      r_wsel     <= 1'b0;
    end else if (ce_pix) begin
      r_hs_in <= HSync_in;
      r_vs_in <= VSync_in;
      if (w_line_start) begin
        r_in_hcnt <= CNT_ONE;
        r_hs_cnt  <= CNT_ONE;
        r_wsel    <= ~r_wsel;
        r_seen    <= 1'b1;
        if (r_seen) begin
          r_line_len <= r_in_hcnt;
        end
      end else begin
        if (r_in_hcnt != CNT_MAX) begin
          r_in_hcnt <= r_in_hcnt + CNT_ONE;
        end
        if ((HSync_in == SYNC_ACTIVE) && (r_hs_cnt != CNT_MAX)) begin
          r_hs_cnt <= r_hs_cnt + CNT_ONE;
        end
        if (w_hs_rise) begin
          r_hs_len <= r_hs_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sd_hcnt <= '0;
    end else if (ce_pix_x2) begin
      if (w_line_start || (r_sd_hcnt == r_line_len - CNT_ONE)) begin
        r_sd_hcnt <= '0;
      end else begin
        r_sd_hcnt <= r_sd_hcnt + CNT_ONE;
      end
    end
  end

  assign w_hs_active = (r_line_len != '0) && (r_sd_hcnt < r_hs_len);

  // Sync and blanking travel alongside the RAM read so both land together.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_hs_low   <= 1'b0;
      r_s1_blank    <= 1'b1;
      r_s1_len_zero <= 1'b1;
      r_s1_vs       <= SYNC_IDLE;
    end else begin
      r_s1_hs_low   <= w_hs_active;
      r_s1_blank    <= w_hs_active || (r_sd_hcnt >= r_line_len);
      r_s1_len_zero <= (r_line_len == '0);
      if ((r_line_len != '0) && (r_sd_hcnt == '0)) begin
        r_s1_vs <= r_vs_in;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      R_out     <= '0;
      G_out     <= '0;
      B_out     <= '0;
      HSync_out <= SYNC_IDLE;
      VSync_out <= SYNC_IDLE;
    end else if (enable) begin
      {R_out, G_out, B_out} <= r_s1_blank ? '0 : w_rdata;
      HSync_out <= r_s1_hs_low ? SYNC_ACTIVE : SYNC_IDLE;
      VSync_out <= r_s1_len_zero ? SYNC_IDLE : r_s1_vs;
    end else if (ce_pix) begin
      R_out     <= R_in;
      G_out     <= G_in;
      B_out     <= B_in;
      HSync_out <= HSync_in;
      VSync_out <= VSync_in;
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Bench for scandoubler: drives whole video lines and compares every output
// sample against a line-level reference model (captured lines replayed by position).
module tb_scandoubler;
  import video_pkg::*;

  localparam int W    = HCNT_W_DEF;
  localparam int MAXC = (1 << W) - 1;
  localparam logic [25:0] RESET_OUT = {24'h0, 2'b11};

  logic       clk_sys   = 1'b0;
  logic       reset_n   = 1'b0;
  logic       ce_pix    = 1'b0;
  logic       ce_pix_x2 = 1'b1;
  logic       enable    = 1'b1;
  logic [7:0] R_in = '0, G_in = '0, B_in = '0;
  logic       HSync_in = 1'b1, VSync_in = 1'b1;
  logic [7:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out;

  scandoubler #(.HCNT_W(HCNT_W_DEF), .COLOR_W(COLOR_W_DEF)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ce_pix    (ce_pix),
    .ce_pix_x2 (ce_pix_x2),
    .enable    (enable),
    .R_in      (R_in),
    .G_in      (G_in),
    .B_in      (B_in),
    .HSync_in  (HSync_in),
    .VSync_in  (VSync_in),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .HSync_out (HSync_out),
    .VSync_out (VSync_out)
  );

  always #5 clk_sys = ~clk_sys;

  int    checks = 0;
  int    errors = 0;
  string phase = "reset";
  bit    checking = 1'b0;
  int    skipStarts = 0;
  bit    countVs = 1'b0;
  int    vsLowCycles = 0;

  rgb_t        curLine [MAXC+1];
  rgb_t        prevLine[MAXC+1];
  int          curCount, lineLen, hsLen, hsCnt, j;
  bit          seen, prevHs, vin, mVs, mStart;
  logic [25:0] pipe[$];
  logic [25:0] expOut;

  task automatic checkOutput(input string tag, input logic [25:0] observed, input logic [25:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    curCount = 0; lineLen = 0; hsLen = 0; hsCnt = 0; j = 0;
    seen = 1'b0; prevHs = 1'b1; vin = 1'b1; mVs = 1'b1; mStart = 1'b0;
    pipe.delete();
    pipe.push_back(RESET_OUT);
    pipe.push_back(RESET_OUT);
    expOut = RESET_OUT;
  endtask

  // One clk_sys edge: capture/line bookkeeping, replay position, 2-clk output latency.
  task automatic modelStep();
    rgb_t        px;
    logic [23:0] pv;
    logic [25:0] dbl;
    int          sd;
    bit          hsLow;
    mStart = 1'b0;
    if (ce_pix) begin
      px.r = R_in; px.g = G_in; px.b = B_in;
      if (prevHs && !HSync_in) begin
        mStart = 1'b1;
        if (seen) lineLen = curCount;
        seen = 1'b1;
        prevLine = curLine;
        curCount = 0;
        hsCnt = 1;
      end else begin
        if (!HSync_in && hsCnt < MAXC) hsCnt++;
        if (!prevHs && HSync_in) hsLen = hsCnt;
      end
      if (curCount < MAXC) begin
        curLine[curCount] = px;
        curCount++;
      end
      prevHs = HSync_in;
      vin = VSync_in;
    end
    j = mStart ? 0 : j + 1;
    if (lineLen != 0) begin
      sd = j % lineLen;
      hsLow = (sd < hsLen);
      if (sd == 0) mVs = vin;
      pv = prevLine[sd];
      dbl = {hsLow ? 24'h0 : pv, ~hsLow, mVs};
    end else begin
      dbl = RESET_OUT;
    end
    pipe.push_back(dbl);
    dbl = pipe.pop_front();
    if (enable) expOut = dbl;
    else if (ce_pix) expOut = {R_in, G_in, B_in, HSync_in, VSync_in};
  endtask

  task automatic cycle();
    @(posedge clk_sys);
    if (reset_n) modelStep();
    else modelReset();
    #1;
    if (mStart && skipStarts > 0) begin
      skipStarts--;
      if (skipStarts == 0) checking = 1'b1;
    end
    if (checking) checkOutput(phase, {R_out, G_out, B_out, HSync_out, VSync_out}, expOut);
    if (countVs && !VSync_out) vsLowCycles++;
  endtask

  task automatic applyStimulus(input logic [23:0] px, input logic hs, input logic vs);
    ce_pix = 1'b1;
    {R_in, G_in, B_in} = px;
    HSync_in = hs;
    VSync_in = vs;
    cycle();
    ce_pix = 1'b0;
    cycle();
  endtask

  task automatic sendLine(input int len, input int hsw, input bit vs, input int mode, input int togglePos);
    logic [23:0] px;
    for (int n = 0; n < len; n++) begin
      if (n == togglePos) begin
        enable = ~enable;
        checking = 1'b0;
        skipStarts = 2;
      end
      px = (mode == 0) ? {3{n[7:0]}} : 24'($urandom);
      applyStimulus(px, (n < hsw) ? 1'b0 : 1'b1, vs);
    end
  endtask

  task automatic asyncReset();
    #2 reset_n = 1'b0;
    #1 checkOutput("rst_async", {R_out, G_out, B_out, HSync_out, VSync_out}, RESET_OUT);
    modelReset();
    repeat (3) cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [23:0] px;
    modelReset();
    checking = 1'b1;
    repeat (4) cycle();
    reset_n = 1'b1;

    phase = "first_line";
    repeat (2) sendLine(400, 32, 1'b1, 0, -1);

    phase = "double";
    repeat (4) sendLine(400, 32, 1'b1, 0, -1);

    phase = "vsync";
    vsLowCycles = 0;
    countVs = 1'b1;
    sendLine(400, 32, 1'b1, 0, -1);
    repeat (3) sendLine(400, 32, 1'b0, 0, -1);
    repeat (2) sendLine(400, 32, 1'b1, 0, -1);
    countVs = 1'b0;
    checkOutput("vs_low_len", 26'(vsLowCycles), 26'd2400);

    phase = "random";
    repeat (6) sendLine($urandom_range(300, 500), $urandom_range(8, 48),
                        ($urandom_range(0, 3) != 0), 1, -1);

    phase = "overlong";
    sendLine(1100, 32, 1'b1, 1, -1);
    repeat (2) sendLine(400, 32, 1'b1, 1, -1);

    phase = "early";
    sendLine(400, 32, 1'b1, 0, -1);
    sendLine(75, 32, 1'b1, 0, -1);
    repeat (2) sendLine(400, 32, 1'b1, 0, -1);

    phase = "bypass";
    enable = 1'b0;
    for (int n = 0; n < 600; n++) begin
      px = 24'($urandom);
      applyStimulus(px, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    sendLine(400, 32, 1'b1, 1, -1);
    sendLine(400, 32, 1'b1, 1, 200);
    repeat (3) sendLine(400, 32, 1'b1, 0, -1);
    sendLine(400, 32, 1'b1, 1, 123);
    repeat (3) sendLine(400, 32, 1'b1, 1, -1);
    enable = 1'b1;
    checking = 1'b0;
    skipStarts = 2;
    repeat (3) sendLine(400, 32, 1'b1, 0, -1);

    phase = "mid_reset";
    for (int n = 0; n < 400; n++) begin
      if (n == 150) asyncReset();
      px = {3{8'(n)}};
      applyStimulus(px, (n < 32) ? 1'b0 : 1'b1, 1'b1);
    end
    repeat (3) sendLine(400, 32, 1'b1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scandoubler.md
Name: scandoubler

Overview:
- Line doubler between the PET video core (15 kHz, one pixel per ce_pix) and the osd stage, which it feeds directly.
- Stores each incoming line in a ping-pong line buffer. Replays the previous line twice at double pixel rate, producing ~31 kHz VGA timing with regenerated sync.
- When doubling is on, the osd stage must be driven with its doublescan input high.
- Bypass mode passes core video through registered, one clock late.

Parameters:
- HCNT_W, 10: width of horizontal counters. Line buffer depth is 2**HCNT_W pixels.
- COLOR_W, 8: bits per colour channel.

Ports:
- clk_sys, in, 1: system clock. Single clock domain.
- reset_n, in, 1: asynchronous, active-low reset.
- ce_pix, in, 1: input pixel enable. Every ce_pix coincides with a ce_pix_x2.
- ce_pix_x2, in, 1: output pixel enable, exactly twice the ce_pix rate.
- enable, in, 1: 1 = doubling, 0 = registered bypass.
- R_in, G_in, B_in, in, COLOR_W each: core colour.
- HSync_in, VSync_in, in, 1 each: core syncs, active-low.
- R_out, G_out, B_out, out, COLOR_W each: video to the osd stage.
- HSync_out, VSync_out, out, 1 each: regenerated syncs, active-low.

Behaviour:
- Reset (async assert, sync release): all colour outputs 0, HSync_out = VSync_out = 1, all counters 0, wsel = 0, line_len = 0, hs_len = 0.
- Input side, on ce_pix:
  - Edge detection: register HSync_in; a falling edge marks line start.
  - in_hcnt increments each ce_pix and clears to 0 at line start.
  - At line start: line_len <= in_hcnt (pixels in the finished line), then toggle wsel.
  - in_hcnt saturates at 2**HCNT_W-1. Writes at the saturated address are suppressed.
  - Pixel {R_in,G_in,B_in} is written to buffer[wsel][in_hcnt] every ce_pix, including during blanking.
  - hs_len counts ce_pix ticks HSync_in stays low after line start, latched when HSync_in rises.
- Output side, on ce_pix_x2:
  - sd_hcnt clears to 0 on the input line-start tick.
  - sd_hcnt also clears when it reaches line_len-1; otherwise it increments. This gives two output lines per input line.
  - Read address is sd_hcnt into buffer[~wsel]. The RAM read takes 1 clk; output registers take 1 more clk.
  - HSync_out = 0 while sd_hcnt < hs_len.
  - Colour is forced to 0 while HSync_out = 0 or sd_hcnt >= line_len.
- VSync: VSync_out takes the registered VSync_in value only at output line starts (sd_hcnt == 0). Vertical sync length therefore doubles in lines.
- Latency: output pixel n of both replays = input pixel n of the previous line. Output lags the input line start by one input line plus 2 clk_sys.
- Read and write never target the same buffer. No read-during-write hazard.
- line_len == 0 (first line after reset): outputs black with syncs high until the first complete line is captured.
- Line longer than 2**HCNT_W: line_len saturates, and the replay is truncated at 2**HCNT_W-1.
- Input line start arriving mid-replay: sd_hcnt restarts immediately. Input wins; a partial replay is acceptable.
- enable = 0: outputs <= inputs on ce_pix (1 clk latency). The buffer-write logic keeps running, so switching enable takes effect cleanly at the next line start.
- Reset mid-line: outputs return to reset values immediately. The first complete line after release is output black.

Decomposition:
- Package video_pkg:
  - HCNT_W and COLOR_W defaults.
  - Packed pixel type rgb_t = {R,G,B}, 3*COLOR_W bits.
  - Constant SYNC_ACTIVE = 1'b0.
- Sub-module sd_line_ram: simple dual-port RAM, depth 2*2**HCNT_W (wsel is the MSB), width 3*COLOR_W.
  - One write port, one registered read port, both on clk_sys.
  - Synchronous read with 1 clk latency.

Test Plan:
- Reset: hold reset_n=0 mid-frame -> outputs 0, HSync_out = VSync_out = 1. After release, the first line is black.
- Line doubling: lines of 400 ce_pix with HSync_in low for 32 ticks; pixel n = n[7:0] on all channels. Two lines later -> each input line produces two output lines of 400 ce_pix_x2 ticks, with HSync_out low for 32 ticks and pixel values 0..255 repeating.
- VSync: 3 input lines of VSync_in low -> VSync_out low for exactly 6 output lines, edges aligned to sd_hcnt == 0.
- Overlong line: 1100-pixel line with HCNT_W=10 -> line_len = 1023, pixels 1023+ not written, no address wrap-around corruption.
- Bypass: enable=0 with random RGB/sync on ce_pix -> outputs equal inputs delayed 1 clk. Toggling enable mid-line -> clean doubled output from the second line start after the toggle.
- Short/early line: an input line start arriving at sd_hcnt = 150 of a 400-pixel replay -> sd_hcnt restarts at 0 on that tick, and HSync_out goes low for hs_len ticks.
